mem_port_arbiter: RTL and testbench

Shares the single-ported synchronous instruction/data memory between the fetch stage and the data (MEM) stage of the pipelined processor. Every cycle it grants the port to at most one requester, drives the memory control lines, and returns read data one cycle later tagged to the requester that issued the read. It also produces the fetch stall that the fetch sequencer uses to hold PC and IR1. Data accesses have priority; an optional starvation guard bounds how long fetch can be locked out.

---
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between fetch and data stages; data wins, read data returns one cycle later.
// Optional starvation guard for fetch is enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_stall,
  output logic              f_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata
);

  // State names the access issued last cycle, so it directly tags the returning read data.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    F_RD = 2'd1,
    D_RD = 2'd2,
    D_WR = 2'd3
  } state_e;

  state_e state_q;
  state_e state_d;
  logic   guard_fire_s;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt_q;
  logic [CNT_W-1:0] starve_cnt_d;

  assign guard_fire_s = f_req && (starve_cnt_q == CNT_MAX);

  // Count consecutive denied fetch cycles, saturating at the limit.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!f_req || f_gnt) begin
      starve_cnt_d = {CNT_W{1'b0}};
    end else if (starve_cnt_q == CNT_MAX) begin
      starve_cnt_d = starve_cnt_q;
    end else begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      starve_cnt_q <= {CNT_W{1'b0}};
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end
`else
  assign guard_fire_s = 1'b0;
`endif

  // Grant selection, memory port mux and next-state.
  always_comb begin
    f_gnt     = 1'b0;
    d_gnt     = 1'b0;
    mem_addr  = {ADDR_W{1'b0}};
    mem_wdata = {DATA_W{1'b0}};
    mem_read  = 1'b0;
    mem_write = 1'b0;
    state_d   = IDLE;
    if (guard_fire_s) begin
      f_gnt    = 1'b1;
      mem_addr = f_addr;
      mem_read = 1'b1;
      state_d  = F_RD;
    end else if (d_req) begin
      d_gnt    = 1'b1;
      mem_addr = d_addr;
      if (d_we) begin
        mem_wdata = d_wdata;
        mem_write = 1'b1;
        state_d   = D_WR;
      end else begin
        mem_read = 1'b1;
        state_d  = D_RD;
      end
    end else if (f_req) begin
      f_gnt    = 1'b1;
      mem_addr = f_addr;
      mem_read = 1'b1;
      state_d  = F_RD;
    end else begin
      state_d = IDLE;
    end
  end

  // Record the access issued this cycle; reset drops any read in flight.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Response tagging from the recorded access.
  always_comb begin
    f_rvalid = 1'b0;
    d_rvalid = 1'b0;
    case (state_q)
      F_RD:    f_rvalid = 1'b1;
      D_RD:    d_rvalid = 1'b1;
      D_WR:    f_rvalid = 1'b0;
      IDLE:    f_rvalid = 1'b0;
      default: f_rvalid = 1'b0;
    endcase
  end

  assign f_stall = f_req & ~f_gnt;
  assign rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic against a reference model.
// Honours ARB_STARVE_GUARD_EN the same way the design does.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 8;
  localparam int STARVE_MAX = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam logic [7:0] KEY = 8'hB5;

  logic              clock = 1'b0;
  logic              resetn;
  logic              f_req, f_gnt, f_stall, f_rvalid;
  logic [ADDR_W-1:0] f_addr;
  logic              d_req, d_we, d_gnt, d_rvalid;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read, mem_write;
  logic [DATA_W-1:0] mem_rdata = 8'h00;
  logic [DATA_W-1:0] rdata;

  int checks = 0;
  int errors = 0;

  // Reference model state: what was issued last cycle and how long fetch has waited.
  int         prev_kind = 0;   // 0 none, 1 fetch read, 2 data read, 3 store
  logic [7:0] prev_addr = 8'h00;
  int         starve    = 0;
  bit         last_fgnt;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clock(clock), .resetn(resetn),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_stall(f_stall), .f_rvalid(f_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .rdata(rdata)
  );

  always #5 clock = ~clock;

  // Memory stand-in: a read returns address XOR KEY on the next cycle.
  always @(posedge clock) begin
    mem_rdata <= mem_read ? (mem_addr ^ KEY) : 8'h00;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with inputs already applied; checks mid-cycle, then advances one cycle.
  task automatic step(input string tag);
    bit         fire, ef, ed, erd, ewr;
    logic [7:0] ea, ew;
    #3;
    fire = GUARD && f_req && (starve == STARVE_MAX);
    ed   = d_req && !fire;
    ef   = f_req && !ed;
    erd  = ef || (ed && !d_we);
    ewr  = ed && d_we;
    ea   = ef ? f_addr : (ed ? d_addr : 8'h00);
    ew   = ewr ? d_wdata : 8'h00;
    check({tag, ".f_gnt"},     f_gnt,     ef);
    check({tag, ".d_gnt"},     d_gnt,     ed);
    check({tag, ".f_stall"},   f_stall,   f_req && !ef);
    check({tag, ".mem_read"},  mem_read,  erd);
    check({tag, ".mem_write"}, mem_write, ewr);
    check({tag, ".mem_addr"},  mem_addr,  ea);
    check({tag, ".mem_wdata"}, mem_wdata, ew);
    check({tag, ".f_rvalid"},  f_rvalid,  prev_kind == 1);
    check({tag, ".d_rvalid"},  d_rvalid,  prev_kind == 2);
    if (prev_kind == 1 || prev_kind == 2) begin
      check({tag, ".rdata"}, rdata, prev_addr ^ KEY);
    end
    last_fgnt = ef;
    @(posedge clock);
    prev_kind = ef ? 1 : (ed ? (d_we ? 3 : 2) : 0);
    prev_addr = ea;
    if (f_req && !ef) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
    else              starve = 0;
    #1;
  endtask

  task automatic set_in(input bit fr, input logic [7:0] fa, input bit dr, input bit we,
                        input logic [7:0] da, input logic [7:0] wd);
    f_req = fr; f_addr = fa; d_req = dr; d_we = we; d_addr = da; d_wdata = wd;
  endtask

  initial begin
    resetn = 1'b0;
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    #12;
    check("reset.f_rvalid", f_rvalid, 1'b0);
    check("reset.d_rvalid", d_rvalid, 1'b0);
    check("reset.mem_read", mem_read, 1'b0);
    resetn = 1'b1;
    @(posedge clock); #1;

    // Lone fetch
    set_in(1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 8'h00); step("lone_fetch");
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00); step("lone_fetch_rsp");
    check("lone_fetch.rdata_after", {24'd0, 8'h10 ^ KEY}, 32'h0000_00A5);

    // Contention, then fetch once data drops
    set_in(1'b1, 8'h11, 1'b1, 1'b0, 8'h20, 8'h00); step("contend");
    set_in(1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00); step("contend_fetch");
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00); step("contend_rsp");

    // Store
    set_in(1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 8'h5C); step("store");
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00); step("store_rsp");

    // Back-to-back fetch, load, fetch
    set_in(1'b1, 8'h40, 1'b0, 1'b0, 8'h00, 8'h00); step("b2b_f0");
    set_in(1'b0, 8'h00, 1'b1, 1'b0, 8'h41, 8'h00); step("b2b_ld");
    set_in(1'b1, 8'h42, 1'b0, 1'b0, 8'h00, 8'h00); step("b2b_f1");
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00); step("b2b_rsp");

    // Starvation: both held for ten cycles
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, 8'h50, 1'b1, 1'b0, 8'(8'h60 + i), 8'h00);
      step("starve");
      check("starve.fetch_slot", last_fgnt, GUARD && (i == 4 || i == 9));
    end
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00); step("starve_drain");

    // Reset pulse while a fetch read is in flight
    set_in(1'b1, 8'h77, 1'b0, 1'b0, 8'h00, 8'h00); step("rst_fetch");
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    resetn = 1'b0; #1;
    check("rst_mid.f_rvalid", f_rvalid, 1'b0);
    #1; resetn = 1'b1;
    prev_kind = 0; starve = 0;
    set_in(1'b1, 8'h78, 1'b0, 1'b0, 8'h00, 8'h00); step("rst_after");
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00); step("rst_after_rsp");

    // Random traffic; a pending request stays high until granted, its fields may change
    for (int i = 0; i < 300; i++) begin
      bit fr, dr;
      fr = (f_req && !last_fgnt) ? 1'b1 : 1'($urandom_range(0, 1));
      dr = (d_req && !d_gnt)     ? 1'b1 : 1'($urandom_range(0, 2) != 0);
      set_in(fr, 8'($urandom), dr, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
